// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retire trace buffer: the trace record layout and the run/halt state encoding.
package retire_trace_buffer_pkg;

  localparam int TR_SEQ_W  = 32;
  localparam int TR_DATA_W = 32;

  // The final-instruction flag is named is_final because "final" is a reserved word.
  typedef struct packed {
    logic [TR_SEQ_W-1:0]  seq;
    logic                 we;
    logic [4:0]           rd;
    logic [TR_DATA_W-1:0] data;
    logic                 is_final;
  } trace_rec_s;

  typedef enum logic {
    TR_RUN  = 1'b0,
    TR_HALT = 1'b1
  } trace_st_e;

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// Register-array FIFO with extra-MSB pointers; head is read combinationally from the array.
module retire_trace_buffer_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // When full, a simultaneous pop frees the head slot, which is exactly where the new record lands.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + (AW+1)'(1);
      if (pop_ok)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: queues one record per retired instruction, counts drops, latches the final event.
// Optional cycle/retire counters are built only when TRACE_PERF_CNT_EN is defined.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_done,
  input  logic              wb_e,
  input  logic [4:0]        wb_a,
  input  logic [31:0]       wb_d,
  input  logic              done,
  output logic              tr_valid,
  input  logic              tr_ready,
  output trace_rec_s        tr_rec,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              halted,
  output logic              drained,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retire_cnt
);

  trace_st_e         state;
  trace_st_e         state_nxt;
  logic [SEQ_W-1:0]  seq_q;
  logic [DROP_W-1:0] drop_q;
  logic              overflow_q;
  logic              drained_q;
  logic              accept;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  trace_rec_s        rec_in;

  assign accept = ins_done && (state == TR_RUN);
  assign pop    = tr_valid && tr_ready;
  assign drop   = accept && full && !pop;

  always_comb begin
    rec_in          = '0;
    rec_in.seq      = TR_SEQ_W'(seq_q);
    rec_in.we       = wb_e && (wb_a != 5'd0);
    rec_in.rd       = wb_a;
    rec_in.data     = wb_d;
    rec_in.is_final = done;
  end

  retire_trace_buffer_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_rec_s)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (rec_in),
    .pop       (pop),
    .head      (tr_rec),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= TR_RUN;
    else       state <= state_nxt;
  end

  // A dropped final record still halts the trace.
  always_comb begin
    state_nxt = state;
    case (state)
      TR_RUN:  if (accept && done) state_nxt = TR_HALT;
      TR_HALT: state_nxt = TR_HALT;
      default: state_nxt = TR_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q      <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      if (accept) seq_q <= seq_q + SEQ_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
      end
      drained_q <= (state == TR_HALT) && empty;
    end
  end

  assign tr_valid = !empty;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
  assign halted   = (state == TR_HALT);
  assign drained  = drained_q;

`ifdef TRACE_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] retire_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else if (state == TR_RUN) begin
      cycle_q <= cycle_q + 32'd1;
      if (accept) retire_q <= retire_q + 32'd1;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: ordering, overflow/drop, x0 writes, full push+pop, halt, reset.
module tb_retire_trace_buffer;
  import retire_trace_buffer_pkg::*;

`ifdef TRACE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ins_done;
  logic        wb_e;
  logic [4:0]  wb_a;
  logic [31:0] wb_d;
  logic        done;
  logic        tr_valid;
  logic        tr_ready;
  trace_rec_s  tr_rec;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        halted;
  logic        drained;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  retire_trace_buffer #(.DEPTH(8), .SEQ_W(32), .DROP_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .ins_done   (ins_done),
    .wb_e       (wb_e),
    .wb_a       (wb_a),
    .wb_d       (wb_d),
    .done       (done),
    .tr_valid   (tr_valid),
    .tr_ready   (tr_ready),
    .tr_rec     (tr_rec),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .halted     (halted),
    .drained    (drained),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic retire(input logic [4:0] a, input logic [31:0] d, input logic e, input logic fin);
    ins_done = 1'b1;
    wb_a = a;
    wb_d = d;
    wb_e = e;
    done = fin;
    tick();
    ins_done = 1'b0;
    wb_e = 1'b0;
    done = 1'b0;
  endtask

  task automatic pop_one();
    tr_ready = 1'b1;
    tick();
    tr_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ins_done = 1'b0; wb_e = 1'b0; wb_a = '0; wb_d = '0; done = 1'b0; tr_ready = 1'b0;

    // 1: reset state and in-order records with a ready consumer
    do_reset();
    check("rst_valid", 64'(tr_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_drained", 64'(drained), 64'd0);
    check("rst_cycle", 64'(cycle_cnt), 64'd0);
    check("rst_retire", 64'(retire_cnt), 64'd0);
    tr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      retire(5'(5 + i), 32'h11 * 32'(i + 1), 1'b1, 1'b0);
      check("t1_valid", 64'(tr_valid), 64'd1);
      check("t1_seq", 64'(tr_rec.seq), 64'(i));
      check("t1_rd", 64'(tr_rec.rd), 64'(5 + i));
      check("t1_data", 64'(tr_rec.data), 64'(32'h11 * 32'(i + 1)));
      check("t1_we", 64'(tr_rec.we), 64'd1);
    end
    tick();
    check("t1_empty", 64'(tr_valid), 64'd0);
    tr_ready = 1'b0;

    // 2: overflow with a stalled consumer, then drain
    do_reset();
    for (int i = 0; i < 10; i++) retire(5'd1, 32'(i), 1'b1, 1'b0);
    check("t2_drop", 64'(drop_cnt), 64'd2);
    check("t2_ovf", 64'(overflow), 64'd1);
    check("t2_retire", 64'(retire_cnt), PERF ? 64'd10 : 64'd0);
    tr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t2_valid", 64'(tr_valid), 64'd1);
      check("t2_seq", 64'(tr_rec.seq), 64'(k));
      check("t2_data", 64'(tr_rec.data), 64'(k));
      tick();
    end
    check("t2_drained_fifo", 64'(tr_valid), 64'd0);
    tr_ready = 1'b0;
    retire(5'd2, 32'h1234, 1'b1, 1'b0);
    check("t2_seq_after", 64'(tr_rec.seq), 64'd10);
    check("t2_ovf_sticky", 64'(overflow), 64'd1);
    pop_one();

    // 3: write to x0 is not a register write
    retire(5'd0, 32'hDEAD, 1'b1, 1'b0);
    check("t3_we", 64'(tr_rec.we), 64'd0);
    check("t3_rd", 64'(tr_rec.rd), 64'd0);
    check("t3_data", 64'(tr_rec.data), 64'hDEAD);
    check("t3_seq", 64'(tr_rec.seq), 64'd11);
    pop_one();
    check("t3_empty", 64'(tr_valid), 64'd0);

    // 4: full FIFO with push and pop together
    do_reset();
    for (int i = 0; i < 8; i++) retire(5'd3, 32'(i), 1'b1, 1'b0);
    check("t4_nodrop_fill", 64'(drop_cnt), 64'd0);
    tr_ready = 1'b1;
    retire(5'd3, 32'h88, 1'b1, 1'b0);
    check("t4_drop", 64'(drop_cnt), 64'd0);
    check("t4_ovf", 64'(overflow), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      check("t4_valid", 64'(tr_valid), 64'd1);
      check("t4_seq", 64'(tr_rec.seq), 64'(k));
      check("t4_data", 64'(tr_rec.data), (k == 8) ? 64'h88 : 64'(k));
      tick();
    end
    check("t4_empty", 64'(tr_valid), 64'd0);
    tr_ready = 1'b0;

    // 5: final instruction halts; later retirements ignored; drained after pops
    do_reset();
    retire(5'd4, 32'hA0, 1'b1, 1'b0);
    retire(5'd4, 32'hA1, 1'b1, 1'b0);
    check("t5_pre_halt", 64'(halted), 64'd0);
    retire(5'd4, 32'hA2, 1'b1, 1'b1);
    check("t5_halted", 64'(halted), 64'd1);
    retire(5'd4, 32'hA3, 1'b1, 1'b0);
    check("t5_drop_ign", 64'(drop_cnt), 64'd0);
    check("t5_drained_q", 64'(drained), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check("t5_seq", 64'(tr_rec.seq), 64'(k));
      check("t5_final", 64'(tr_rec.is_final), (k == 2) ? 64'd1 : 64'd0);
      check("t5_not_drained", 64'(drained), 64'd0);
      pop_one();
    end
    check("t5_empty", 64'(tr_valid), 64'd0);
    tick();
    check("t5_drained", 64'(drained), 64'd1);
    check("t5_cycle", 64'(cycle_cnt), PERF ? 64'd3 : 64'd0);
    check("t5_retire", 64'(retire_cnt), PERF ? 64'd3 : 64'd0);

    // 6: reset with records queued
    do_reset();
    for (int i = 0; i < 5; i++) retire(5'd9, 32'(i + 100), 1'b1, 1'b0);
    check("t6_queued", 64'(tr_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("t6_valid", 64'(tr_valid), 64'd0);
    check("t6_halted", 64'(halted), 64'd0);
    check("t6_cycle", 64'(cycle_cnt), 64'd0);
    check("t6_retire", 64'(retire_cnt), 64'd0);
    reset = 1'b0;
    tick();
    check("t6_still_empty", 64'(tr_valid), 64'd0);
    retire(5'd9, 32'h77, 1'b1, 1'b0);
    check("t6_seq", 64'(tr_rec.seq), 64'd0);
    check("t6_data", 64'(tr_rec.data), 64'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
